// File: rtl/row_enc_pkg.sv
// row_enc_pkg: shared defaults and FSM state type for the row encoder.
package row_enc_pkg;
  localparam int ROWS_DEF = 16;
  localparam int AW_DEF = 4;
  typedef enum logic {IDLE, SERVE} state_t;
endpackage

// File: rtl/prio_enc.sv
// prio_enc: lowest-set-bit index of a ROWS-wide vector plus an any-bit flag.
module prio_enc
  import row_enc_pkg::*;
#(
  parameter int ROWS = ROWS_DEF,
  parameter int AW = AW_DEF
) (
  input  logic [ROWS-1:0] vec,
  output logic [AW-1:0]   idx,
  output logic            any
);
  always_comb begin
    idx = '0;
    for (int i = ROWS - 1; i >= 0; i--) idx = vec[i] ? AW'(i) : idx;
    any = |vec;
  end
endmodule

// File: rtl/row_encoder.sv
// row_encoder: accepts a multi-hot row vector and streams out the set row indices, lowest first.
module row_encoder
  import row_enc_pkg::*;
#(
  parameter int ROWS = ROWS_DEF,
  parameter int AW = AW_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [ROWS-1:0] req_vec,
  input  logic            flush,
  output logic            addr_valid,
  input  logic            addr_ready,
  output logic [AW-1:0]   addr_out,
  output logic            addr_last,
  output logic [AW:0]     req_count,
  output logic            zero_err
);
  state_t state, state_nxt;
  logic [ROWS-1:0] pending, pending_nxt;
  logic [AW:0] pop;
  logic any, accept, xfer;
  prio_enc #(.ROWS(ROWS), .AW(AW)) u_prio (.vec(pending), .idx(addr_out), .any(any));
  assign req_ready = state == IDLE;
  assign addr_valid = (state == SERVE) & any;
  // exactly one bit left: clearing the lowest set bit leaves nothing
  assign addr_last = addr_valid & ~|(pending & (pending - ROWS'(1)));
  assign accept = req_valid & req_ready;
  assign xfer = addr_valid & addr_ready & ~flush;
  always_comb begin
    pop = '0;
    for (int i = 0; i < ROWS; i++) pop = pop + (AW+1)'(req_vec[i]);
  end
  always_comb begin
    state_nxt = state;
    pending_nxt = pending;
    if (state == IDLE) begin
      pending_nxt = accept ? req_vec : pending;
      state_nxt = (accept && |req_vec) ? SERVE : IDLE;
    end else if (flush) begin
      pending_nxt = '0;
      state_nxt = IDLE;
    end else if (xfer) begin
      pending_nxt = pending & ~(ROWS'(1) << addr_out);
      state_nxt = addr_last ? IDLE : SERVE;
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_nxt;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      pending <= '0;
      req_count <= '0;
      zero_err <= 1'b0;
    end else begin
      pending <= pending_nxt;
      req_count <= accept ? pop : req_count;
      zero_err <= accept & ~|req_vec;
    end
endmodule

// File: tb/tb_row_encoder.sv
// tb_row_encoder: directed-vector checks of row_encoder, inputs driven and outputs sampled on the falling edge.
module tb_row_encoder;
  localparam int ROWS = 16;
  localparam int AW = 4;
  logic clk = 1'b0, rst = 1'b1, req_valid = 1'b0, flush = 1'b0, addr_ready = 1'b0;
  logic [ROWS-1:0] req_vec = '0;
  logic req_ready, addr_valid, addr_last, zero_err;
  logic [AW-1:0] addr_out;
  logic [AW:0] req_count;
  int errors = 0, checks = 0;

  row_encoder #(.ROWS(ROWS), .AW(AW)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_vec(req_vec),
    .flush(flush), .addr_valid(addr_valid), .addr_ready(addr_ready), .addr_out(addr_out),
    .addr_last(addr_last), .req_count(req_count), .zero_err(zero_err)
  );

  always #5 clk = ~clk;

  task automatic send(input logic [ROWS-1:0] v);
    @(negedge clk);
    req_valid = 1'b1;
    req_vec = v;
    @(negedge clk);
    req_valid = 1'b0;
    req_vec = '0;
  endtask

  task automatic test_reset;
    #2;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", req_ready); end
    checks++; if (addr_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", addr_valid); end
    checks++; if (addr_out !== 4'd0 || addr_last !== 1'b0) begin errors++; $display("FAIL reset_addr got=%0d/%b exp=0/0", addr_out, addr_last); end
    checks++; if (req_count !== 5'd0 || zero_err !== 1'b0) begin errors++; $display("FAIL reset_count got=%0d/%b exp=0/0", req_count, zero_err); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_single;
    send(16'h0001);
    checks++; if (addr_valid !== 1'b1 || addr_out !== 4'd0 || addr_last !== 1'b1) begin errors++; $display("FAIL single_addr got=%b/%0d/%b exp=1/0/1", addr_valid, addr_out, addr_last); end
    checks++; if (req_count !== 5'd1 || req_ready !== 1'b0) begin errors++; $display("FAIL single_count got=%0d/%b exp=1/0", req_count, req_ready); end
    addr_ready = 1'b1;
    @(negedge clk);
    addr_ready = 1'b0;
    checks++; if (addr_valid !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL single_done got=%b/%b exp=0/1", addr_valid, req_ready); end
  endtask

  task automatic test_multi;
    logic [AW-1:0] exp_a [4] = '{4'd0, 4'd5, 4'd10, 4'd15};
    send(16'h8421);
    addr_ready = 1'b1;
    checks++; if (req_count !== 5'd4) begin errors++; $display("FAIL multi_count got=%0d exp=4", req_count); end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (addr_valid !== 1'b1 || addr_out !== exp_a[k] || addr_last !== (k == 3)) begin
        errors++; $display("FAIL multi_addr%0d got=%b/%0d/%b exp=1/%0d/%b", k, addr_valid, addr_out, addr_last, exp_a[k], k == 3);
      end
      @(negedge clk);
    end
    addr_ready = 1'b0;
    checks++; if (addr_valid !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL multi_done got=%b/%b exp=0/1", addr_valid, req_ready); end
  endtask

  task automatic test_zero;
    send(16'h0000);
    checks++; if (zero_err !== 1'b1 || addr_valid !== 1'b0) begin errors++; $display("FAIL zero_pulse got=%b/%b exp=1/0", zero_err, addr_valid); end
    checks++; if (req_count !== 5'd0 || req_ready !== 1'b1) begin errors++; $display("FAIL zero_count got=%0d/%b exp=0/1", req_count, req_ready); end
    @(negedge clk);
    checks++; if (zero_err !== 1'b0 || addr_valid !== 1'b0) begin errors++; $display("FAIL zero_end got=%b/%b exp=0/0", zero_err, addr_valid); end
  endtask

  task automatic test_full;
    send(16'hFFFF);
    checks++; if (req_count !== 5'd16) begin errors++; $display("FAIL full_count got=%0d exp=16", req_count); end
    for (int k = 0; k < 16; k++) begin
      addr_ready = 1'b0;
      checks++;
      if (addr_valid !== 1'b1 || addr_out !== AW'(k) || addr_last !== (k == 15)) begin
        errors++; $display("FAIL full_addr%0d got=%b/%0d/%b exp=1/%0d/%b", k, addr_valid, addr_out, addr_last, k, k == 15);
      end
      @(negedge clk);
      checks++;
      if (addr_valid !== 1'b1 || addr_out !== AW'(k) || addr_last !== (k == 15)) begin
        errors++; $display("FAIL full_stall%0d got=%b/%0d/%b exp=1/%0d/%b", k, addr_valid, addr_out, addr_last, k, k == 15);
      end
      addr_ready = 1'b1;
      @(negedge clk);
    end
    addr_ready = 1'b0;
    checks++; if (addr_valid !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL full_done got=%b/%b exp=0/1", addr_valid, req_ready); end
  endtask

  task automatic test_flush;
    send(16'h00F0);
    addr_ready = 1'b1;
    checks++; if (addr_out !== 4'd4) begin errors++; $display("FAIL flush_first got=%0d exp=4", addr_out); end
    @(negedge clk);
    checks++; if (addr_out !== 4'd5 || addr_valid !== 1'b1) begin errors++; $display("FAIL flush_second got=%0d/%b exp=5/1", addr_out, addr_valid); end
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    addr_ready = 1'b0;
    checks++; if (addr_valid !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL flush_idle got=%b/%b exp=0/1", addr_valid, req_ready); end
    checks++; if (req_count !== 5'd4) begin errors++; $display("FAIL flush_count got=%0d exp=4", req_count); end
    @(negedge clk);
    checks++; if (addr_valid !== 1'b0) begin errors++; $display("FAIL flush_stay got=%b exp=0", addr_valid); end
  endtask

  task automatic test_flush_idle;
    flush = 1'b1;
    send(16'h0006);
    flush = 1'b0;
    checks++; if (addr_valid !== 1'b1 || addr_out !== 4'd1 || req_count !== 5'd2) begin errors++; $display("FAIL flush_idle_accept got=%b/%0d/%0d exp=1/1/2", addr_valid, addr_out, req_count); end
    addr_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    addr_ready = 1'b0;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL flush_idle_done got=%b exp=1", req_ready); end
  endtask

  task automatic test_async_reset;
    send(16'hFFFF);
    addr_ready = 1'b1;
    @(negedge clk);
    addr_ready = 1'b0;
    #2 rst = 1'b1;
    #1;
    checks++; if (addr_valid !== 1'b0 || req_ready !== 1'b1 || addr_out !== 4'd0 || addr_last !== 1'b0) begin errors++; $display("FAIL arst_out got=%b/%b/%0d/%b exp=0/1/0/0", addr_valid, req_ready, addr_out, addr_last); end
    checks++; if (req_count !== 5'd0 || zero_err !== 1'b0) begin errors++; $display("FAIL arst_count got=%0d/%b exp=0/0", req_count, zero_err); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++; if (addr_valid !== 1'b0) begin errors++; $display("FAIL arst_discard got=%b exp=0", addr_valid); end
    send(16'h0002);
    checks++; if (addr_valid !== 1'b1 || addr_out !== 4'd1 || addr_last !== 1'b1 || req_count !== 5'd1) begin errors++; $display("FAIL arst_new got=%b/%0d/%b/%0d exp=1/1/1/1", addr_valid, addr_out, addr_last, req_count); end
    addr_ready = 1'b1;
    @(negedge clk);
    addr_ready = 1'b0;
  endtask

  initial begin
    test_reset;
    test_single;
    test_multi;
    test_zero;
    test_full;
    test_flush;
    test_flush_idle;
    test_async_reset;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/row_encoder.md
ROW_ENCODER -- requirements
Module: row_encoder

Interface
REQ-001 SHALL have parameter ROWS, default 16, the number of row request lines.
REQ-002 SHALL have parameter AW, default 4, the address width, equal to log2(ROWS).
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port req_valid, input, 1, a request vector is offered.
REQ-006 SHALL have port req_ready, output, 1, the block can accept a vector.
REQ-007 SHALL have port req_vec, input, ROWS, multi-hot row request vector; bit i requests row i.
REQ-008 SHALL have port flush, input, 1, synchronous abort of the vector in progress.
REQ-009 SHALL have port addr_valid, output, 1, addr_out holds a valid row address.
REQ-010 SHALL have port addr_ready, input, 1, the consumer accepts addr_out.
REQ-011 SHALL have port addr_out, output, AW, binary row index, i.e. the inverse of the row decoder mapping.
REQ-012 SHALL have port addr_last, output, 1, addr_out is the final row of the current vector.
REQ-013 SHALL have port req_count, output, AW+1, popcount of the last accepted vector.
REQ-014 SHALL have port zero_err, output, 1, one-cycle pulse when an all-zero vector is accepted.

Function
REQ-015 SHALL implement the state machine IDLE -> SERVE -> IDLE; req_ready = 1 only in IDLE.
REQ-016 SHALL, on req_valid & req_ready at edge N, register req_vec into a pending register and req_count = popcount(req_vec).
REQ-017 SHALL, for a non-zero vector, enter SERVE with addr_valid = 1 from cycle N+1 (one-cycle latency).
REQ-018 SHALL, for an all-zero vector, stay in IDLE, set req_count = 0, and pulse zero_err for exactly cycle N+1.
REQ-019 SHALL in SERVE drive addr_out = index of the lowest set bit of pending (lowest index first), and addr_last = 1 when exactly one bit is set.
REQ-020 SHALL hold addr_out, addr_valid and addr_last stable while addr_valid & !addr_ready.
REQ-021 SHALL, on addr_valid & addr_ready, clear the served bit; the next address appears the following cycle with no bubble.
REQ-022 SHALL, on the handshake with addr_last = 1, return to IDLE so that req_ready = 1 in the next cycle; a new vector is never accepted in the same cycle as the last address transfer.
REQ-023 SHALL, on flush in SERVE, clear pending, deassert addr_valid next cycle and return to IDLE; flush wins over a simultaneous address handshake; req_count is kept.
REQ-024 SHALL ignore flush in IDLE, and SHALL ignore req_vec and req_valid outside IDLE.
REQ-025 SHALL serve a vector with all ROWS bits set as ROWS transfers, addresses 0..ROWS-1, with req_count = ROWS (no overflow in AW+1 bits).

Reset
REQ-026 SHALL, while rst = 1, force state = IDLE, pending = 0, addr_valid = 0, addr_out = 0, addr_last = 0, req_count = 0, zero_err = 0 and req_ready = 1, independent of clk.
REQ-027 SHALL, on rst asserted mid-SERVE, discard the vector with no further addresses issued.

Structure
REQ-028 SHALL place ROWS/AW defaults and the state enum (IDLE, SERVE) in shared package row_enc_pkg.
REQ-029 SHALL contain one combinational sub-module prio_enc, mapping ROWS bits to an AW-bit lowest-set index plus a one-bit any signal, reused for the addr_out computation.
REQ-030 SHALL compute popcount and the addr_last detection in row_encoder itself; no other sub-modules.

Verification
REQ-031 SHALL check req_vec=16'h0001 -> one transfer: addr_out=0, addr_last=1, req_count=1, then req_ready=1.
REQ-032 SHALL check req_vec=16'h8421 with addr_ready held 1 -> addresses 0,5,10,15 on consecutive cycles, addr_last only on 15, req_count=4.
REQ-033 SHALL check req_vec=16'h0000 -> zero_err pulses for one cycle, addr_valid stays 0, req_count=0.
REQ-034 SHALL check req_vec=16'hFFFF with addr_ready toggling 1/0 -> 16 transfers 0..15, outputs stable while stalled, req_count=16.
REQ-035 SHALL check req_vec=16'h00F0 with flush asserted together with the second handshake -> only address 4 is counted as delivered, addr_valid=0 next cycle, IDLE.
REQ-036 SHALL check rst asserted asynchronously mid-SERVE -> all outputs equal the reset values immediately; a new vector is accepted after release.
